alu_issue_stage: RTL and testbench

- Issue stage that drives the single-cycle ALU's operand and control inputs; it is the initiator side of the ALU interface.
- Decodes an RV32I instruction word into the 4-bit ALU control code and selects operands (register data or sign-extended immediate).
- Holds the result in a two-entry valid/ready elastic buffer (main register plus skid register), so the upstream fetch/decode logic and the ALU consumer can stall independently.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_op_decode.sv | 55 +++++
 rtl/alu_issue_stage.sv | 72 +++++++
 tb/tb_alu_issue_stage.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU control codes, RV32I opcodes and the issue-entry record
package alu_pkg;
   localparam int ALU_XLEN = 32;
   localparam int ALU_CW = 4;
   localparam logic [ALU_CW-1:0] ALU_AND = 4'b0000;
   localparam logic [ALU_CW-1:0] ALU_OR  = 4'b0001;
   localparam logic [ALU_CW-1:0] ALU_ADD = 4'b0010;
   localparam logic [ALU_CW-1:0] ALU_SUB = 4'b0110;
   localparam logic [ALU_CW-1:0] ALU_ILL = 4'b1111;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   typedef struct packed {
      logic [ALU_CW-1:0]   ctrl;
      logic [ALU_XLEN-1:0] in1;
      logic [ALU_XLEN-1:0] in2;
      logic                illegal;
   } issue_entry_t;
endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: combinational RV32I instruction to ALU issue-entry decode
module alu_op_decode
   import alu_pkg::*;
(
   input  logic [31:0]         instr,
   input  logic [ALU_XLEN-1:0] rs1_data,
   input  logic [ALU_XLEN-1:0] rs2_data,
   output issue_entry_t        entry
);
   logic [6:0] opc;
   logic [6:0] f7;
   logic [2:0] f3;
   logic [ALU_CW-1:0] ctrl;
   logic use_rs2;
   logic [ALU_XLEN-1:0] imm_i;
   logic [ALU_XLEN-1:0] imm_s;
   logic [ALU_XLEN-1:0] imm;
   logic unused_rs_idx;
   assign opc = instr[6:0];
   assign f3 = instr[14:12];
   assign f7 = instr[31:25];
   assign imm_i = {{(ALU_XLEN-12){instr[31]}}, instr[31:20]};
   assign imm_s = {{(ALU_XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
   assign unused_rs_idx = ^instr[19:15];
   always_comb begin
      ctrl = ALU_ILL;
      use_rs2 = 1'b0;
      imm = imm_i;
      case (opc)
         OP_R: begin
            use_rs2 = 1'b1;
            ctrl = (f3 == 3'b000 && f7 == 7'b0000000) ? ALU_ADD :
                   (f3 == 3'b000 && f7 == 7'b0100000) ? ALU_SUB :
                   (f3 == 3'b111 && f7 == 7'b0000000) ? ALU_AND :
                   (f3 == 3'b110 && f7 == 7'b0000000) ? ALU_OR  : ALU_ILL;
         end
         OP_I: ctrl = (f3 == 3'b000) ? ALU_ADD : (f3 == 3'b111) ? ALU_AND :
                      (f3 == 3'b110) ? ALU_OR  : ALU_ILL;
         OP_LOAD: ctrl = ALU_ADD;
         OP_STORE: begin
            ctrl = ALU_ADD;
            imm = imm_s;
         end
         OP_BRANCH: begin
            use_rs2 = 1'b1;
            ctrl = (f3 == 3'b000) ? ALU_SUB : ALU_ILL;
         end
         default: ctrl = ALU_ILL;
      endcase
   end
   assign entry.ctrl = ctrl;
   assign entry.illegal = (ctrl == ALU_ILL);
   assign entry.in1 = entry.illegal ? '0 : rs1_data;
   assign entry.in2 = entry.illegal ? '0 : (use_rs2 ? rs2_data : imm);
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes RV32I ALU ops into a two-entry main/skid elastic buffer feeding the ALU
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int XLEN = ALU_XLEN,
   parameter int CTRL_W = ALU_CW
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              Flush,
   input  logic              In_Valid,
   output logic              In_Ready,
   input  logic [31:0]       Instr,
   input  logic [XLEN-1:0]   RS1_Data,
   input  logic [XLEN-1:0]   RS2_Data,
   output logic              Out_Valid,
   input  logic              Out_Ready,
   output logic [CTRL_W-1:0] ALU_Control,
   output logic [XLEN-1:0]   ALU_In1,
   output logic [XLEN-1:0]   ALU_In2,
   output logic              Illegal
);
   typedef enum logic [1:0] {EMPTY, FULL1, FULL2} state_t;
   state_t state, st_d;
   issue_entry_t dec, main_q, skid_q;
   logic in_ready_q, out_valid_q, accept;
   alu_op_decode u_dec (
      .instr(Instr),
      .rs1_data(RS1_Data),
      .rs2_data(RS2_Data),
      .entry(dec)
   );
   assign accept = In_Valid & in_ready_q & ~Flush;
   always_comb begin
      st_d = state;
      case (state)
         EMPTY: st_d = accept ? FULL1 : EMPTY;
         FULL1: st_d = (accept & ~Out_Ready) ? FULL2 : (~accept & Out_Ready) ? EMPTY : FULL1;
         FULL2: st_d = Out_Ready ? FULL1 : FULL2;
         default: st_d = EMPTY;
      endcase
      if (Flush) st_d = EMPTY;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= EMPTY;
         in_ready_q <= 1'b1;
         out_valid_q <= 1'b0;
         main_q <= '0;
         skid_q <= '0;
      end else begin
         state <= st_d;
         in_ready_q <= (st_d != FULL2);
         out_valid_q <= (st_d != EMPTY);
         case (state)
            EMPTY: if (accept) main_q <= dec;
            FULL1: begin
               if (accept & Out_Ready) main_q <= dec;
               else if (accept) skid_q <= dec;
            end
            FULL2: if (Out_Ready) main_q <= skid_q;
            default: ;
         endcase
      end
   end
   assign In_Ready = in_ready_q;
   assign Out_Valid = out_valid_q;
   assign ALU_Control = main_q.ctrl;
   assign ALU_In1 = main_q.in1;
   assign ALU_In2 = main_q.in2;
   assign Illegal = main_q.illegal;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed self-checking bench for the ALU issue stage
module tb_alu_issue_stage;
   logic clk = 1'b0;
   logic reset, Flush, In_Valid, In_Ready, Out_Valid, Out_Ready, Illegal;
   logic [31:0] Instr, RS1_Data, RS2_Data, ALU_In1, ALU_In2;
   logic [3:0] ALU_Control;
   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   alu_issue_stage dut (
      .clk(clk), .reset(reset), .Flush(Flush),
      .In_Valid(In_Valid), .In_Ready(In_Ready), .Instr(Instr),
      .RS1_Data(RS1_Data), .RS2_Data(RS2_Data),
      .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
      .ALU_Control(ALU_Control), .ALU_In1(ALU_In1), .ALU_In2(ALU_In2),
      .Illegal(Illegal)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] r1, input logic [31:0] r2);
      In_Valid = v;
      Instr = i;
      RS1_Data = r1;
      RS2_Data = r2;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      Flush = 1'b0;
      Out_Ready = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 32'h0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      step();
      total++; if (Out_Valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", Out_Valid); end
      total++; if (In_Ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", In_Ready); end
      total++; if (ALU_Control !== 4'b0000) begin bad++; $display("FAIL reset_ctrl got=%b want=0000", ALU_Control); end
      total++; if ({ALU_In1, ALU_In2, Illegal} !== 65'h0) begin bad++; $display("FAIL reset_data got=%h/%h/%b want=0", ALU_In1, ALU_In2, Illegal); end
   endtask

   task automatic test_add();
      Out_Ready = 1'b1;
      drive(1'b1, 32'h002081B3, 32'd5, 32'd7);
      step();
      drive(1'b0, 32'h0, 32'h0, 32'h0);
      total++; if (Out_Valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%b want=1", Out_Valid); end
      total++; if ({ALU_Control, ALU_In1, ALU_In2, Illegal} !== {4'b0010, 32'd5, 32'd7, 1'b0})
         begin bad++; $display("FAIL add_data got=%b/%h/%h/%b want=0010/5/7/0", ALU_Control, ALU_In1, ALU_In2, Illegal); end
      step();
      total++; if (Out_Valid !== 1'b0) begin bad++; $display("FAIL add_drain got=%b want=0", Out_Valid); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] ins [10] = '{32'h402081B3, 32'hFFF00093, 32'h0020A423, 32'h00208063, 32'h0020F1B3,
                                32'h0020E1B3, 32'h0F00F093, 32'hFF00E093, 32'hFFC12083, 32'hFE20AC23};
      logic [31:0] r1 [10] = '{32'd10, 32'h100, 32'h1000, 32'd20, 32'hF0F0, 32'hF0F0, 32'h33, 32'h1, 32'h2000, 32'h3000};
      logic [31:0] r2 [10] = '{32'd3, 32'h55, 32'h77, 32'd21, 32'hFF00, 32'hFF00, 32'h44, 32'h2, 32'h3, 32'h9};
      logic [3:0] ec [10] = '{4'b0110, 4'b0010, 4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0010, 4'b0010};
      logic [31:0] e2 [10] = '{32'd3, 32'hFFFFFFFF, 32'd8, 32'd21, 32'hFF00, 32'hFF00, 32'hF0, 32'hFFFFFFF0, 32'hFFFFFFFC, 32'hFFFFFFF8};
      Out_Ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         drive(1'b1, ins[k], r1[k], r2[k]);
         step();
         total++; if ({Out_Valid, In_Ready} !== 2'b11) begin bad++; $display("FAIL b2b_hs[%0d] got=%b%b want=11", k, Out_Valid, In_Ready); end
         total++; if ({ALU_Control, ALU_In1, ALU_In2, Illegal} !== {ec[k], r1[k], e2[k], 1'b0})
            begin bad++; $display("FAIL b2b_data[%0d] got=%b/%h/%h/%b want=%b/%h/%h/0", k, ALU_Control, ALU_In1, ALU_In2, Illegal, ec[k], r1[k], e2[k]); end
      end
      drive(1'b0, 32'h0, 32'h0, 32'h0);
      step();
      total++; if (Out_Valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b want=0", Out_Valid); end
   endtask

   task automatic test_illegal();
      logic [31:0] ins [6] = '{32'h0000007F, 32'h202081B3, 32'h00209063, 32'h4020F1B3, 32'h00109093, 32'h0000006F};
      Out_Ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         drive(1'b1, ins[k], 32'hDEAD, 32'hBEEF);
         step();
         total++; if ({Out_Valid, ALU_Control, ALU_In1, ALU_In2, Illegal} !== {1'b1, 4'b1111, 32'h0, 32'h0, 1'b1})
            begin bad++; $display("FAIL illegal[%0d] got=%b/%b/%h/%h/%b want=1/1111/0/0/1", k, Out_Valid, ALU_Control, ALU_In1, ALU_In2, Illegal); end
      end
      drive(1'b0, 32'h0, 32'h0, 32'h0);
      step();
   endtask

   task automatic test_backpressure();
      Out_Ready = 1'b0;
      drive(1'b1, 32'h002081B3, 32'd1, 32'd2);
      step();
      total++; if ({Out_Valid, In_Ready} !== 2'b11) begin bad++; $display("FAIL bp_first_hs got=%b%b want=11", Out_Valid, In_Ready); end
      drive(1'b1, 32'h402081B3, 32'd9, 32'd4);
      step();
      total++; if ({Out_Valid, In_Ready} !== 2'b10) begin bad++; $display("FAIL bp_full2_hs got=%b%b want=10", Out_Valid, In_Ready); end
      drive(1'b1, 32'h0020E1B3, 32'hF0, 32'h0F);
      repeat (2) begin
         step();
         total++; if ({Out_Valid, In_Ready, ALU_Control, ALU_In1, ALU_In2} !== {2'b10, 4'b0010, 32'd1, 32'd2})
            begin bad++; $display("FAIL bp_hold got=%b%b/%b/%h/%h want=10/0010/1/2", Out_Valid, In_Ready, ALU_Control, ALU_In1, ALU_In2); end
      end
      Out_Ready = 1'b1;
      step();
      total++; if ({Out_Valid, In_Ready, ALU_Control, ALU_In1, ALU_In2} !== {2'b11, 4'b0110, 32'd9, 32'd4})
         begin bad++; $display("FAIL bp_second got=%b%b/%b/%h/%h want=11/0110/9/4", Out_Valid, In_Ready, ALU_Control, ALU_In1, ALU_In2); end
      step();
      drive(1'b0, 32'h0, 32'h0, 32'h0);
      total++; if ({Out_Valid, ALU_Control, ALU_In1, ALU_In2} !== {1'b1, 4'b0001, 32'hF0, 32'h0F})
         begin bad++; $display("FAIL bp_third got=%b/%b/%h/%h want=1/0001/f0/0f", Out_Valid, ALU_Control, ALU_In1, ALU_In2); end
      step();
      total++; if (Out_Valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b want=0", Out_Valid); end
   endtask

   task automatic test_flush();
      Out_Ready = 1'b0;
      drive(1'b1, 32'h002081B3, 32'd1, 32'd2);
      step();
      drive(1'b1, 32'h402081B3, 32'd9, 32'd4);
      step();
      Flush = 1'b1;
      Out_Ready = 1'b1;
      drive(1'b1, 32'h0020E1B3, 32'hF0, 32'h0F);
      step();
      Flush = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 32'h0);
      total++; if ({Out_Valid, In_Ready} !== 2'b01) begin bad++; $display("FAIL flush_hs got=%b%b want=01", Out_Valid, In_Ready); end
      step();
      total++; if (Out_Valid !== 1'b0) begin bad++; $display("FAIL flush_not_taken got=%b want=0", Out_Valid); end
      drive(1'b1, 32'h0020F1B3, 32'h33, 32'h3C);
      step();
      drive(1'b0, 32'h0, 32'h0, 32'h0);
      total++; if ({Out_Valid, ALU_Control, ALU_In1, ALU_In2} !== {1'b1, 4'b0000, 32'h33, 32'h3C})
         begin bad++; $display("FAIL flush_next got=%b/%b/%h/%h want=1/0000/33/3c", Out_Valid, ALU_Control, ALU_In1, ALU_In2); end
      step();
   endtask

   task automatic test_async_reset();
      Out_Ready = 1'b0;
      drive(1'b1, 32'h402081B3, 32'd9, 32'd4);
      step();
      drive(1'b0, 32'h0, 32'h0, 32'h0);
      total++; if (Out_Valid !== 1'b1) begin bad++; $display("FAIL arst_pre got=%b want=1", Out_Valid); end
      #2 reset = 1'b1;
      #1;
      total++; if ({Out_Valid, In_Ready, ALU_Control, ALU_In1, ALU_In2, Illegal} !== {2'b01, 4'b0000, 32'h0, 32'h0, 1'b0})
         begin bad++; $display("FAIL arst_clear got=%b%b/%b/%h/%h/%b want=01/0000/0/0/0", Out_Valid, In_Ready, ALU_Control, ALU_In1, ALU_In2, Illegal); end
      reset = 1'b0;
      step();
      total++; if ({Out_Valid, In_Ready} !== 2'b01) begin bad++; $display("FAIL arst_after got=%b%b want=01", Out_Valid, In_Ready); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_back_to_back();
      test_illegal();
      test_backpressure();
      test_flush();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
